// File: rtl/tracker_pkg.sv
// Shared encodings for the line tracker: steering codes (also used by the
// drive decoder), last-seen side, and tracker FSM states.
package tracker_pkg;

    localparam logic [2:0] CMD_TURN_LEFT   = 3'b000;
    localparam logic [2:0] CMD_TURN_RIGHT  = 3'b001;
    localparam logic [2:0] CMD_GO_STRAIGHT = 3'b010;
    localparam logic [2:0] CMD_STOP        = 3'b011;
    localparam logic [2:0] CMD_SHARP_LEFT  = 3'b100;
    localparam logic [2:0] CMD_SHARP_RIGHT = 3'b101;

    typedef enum logic [1:0] {
        SIDE_LEFT   = 2'd0,
        SIDE_CENTER = 2'd1,
        SIDE_RIGHT  = 2'd2
    } side_t;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_TRACK = 2'd1,
        FSM_LOST  = 2'd2,
        FSM_HALT  = 2'd3
    } fsm_t;

    // Pattern is {left, mid, right}; 101 (and 000) keep the previous command.
    function automatic logic [2:0] decode_cmd(input logic [2:0] pattern, input logic [2:0] prev);
        case (pattern)
            3'b010, 3'b111: decode_cmd = CMD_GO_STRAIGHT;
            3'b110:         decode_cmd = CMD_TURN_LEFT;
            3'b011:         decode_cmd = CMD_TURN_RIGHT;
            3'b100:         decode_cmd = CMD_SHARP_LEFT;
            3'b001:         decode_cmd = CMD_SHARP_RIGHT;
            default:        decode_cmd = prev;
        endcase
    endfunction

    function automatic side_t decode_side(input logic [2:0] pattern, input side_t prev);
        case (pattern)
            3'b010, 3'b111: decode_side = SIDE_CENTER;
            3'b110, 3'b100: decode_side = SIDE_LEFT;
            3'b011, 3'b001: decode_side = SIDE_RIGHT;
            default:        decode_side = prev;
        endcase
    endfunction

    function automatic logic [2:0] recover_cmd(input side_t side);
        case (side)
            SIDE_LEFT:  recover_cmd = CMD_SHARP_LEFT;
            SIDE_RIGHT: recover_cmd = CMD_SHARP_RIGHT;
            default:    recover_cmd = CMD_GO_STRAIGHT;
        endcase
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// One IR sensor channel: 2-FF synchroniser, then a tick-sampled run-length
// filter that only flips the output after FILT_LEN consecutive disagreeing samples.
module sensor_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic filtered
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

    logic       sync1_reg, sync2_reg;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_inc;
    logic       filt_reg;

    assign cnt_inc  = cnt_reg + 4'd1;
    assign filtered = filt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= 4'd0;
            filt_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (tick) begin
                if (sync2_reg == filt_reg) begin
                    cnt_reg <= 4'd0;
                end else if (cnt_inc == FILT_MAX) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= 4'd0;
                end else begin
                    cnt_reg <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: rtl/line_tracker_fsm.sv
// Line tracker: filters the three IR sensors and produces the registered
// steering command, with lost-line recovery towards the last seen side.
module line_tracker_fsm
    import tracker_pkg::*;
#(
    parameter int SAMPLE_DIV   = 100000,
    parameter int FILT_LEN     = 4,
    parameter int LOST_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_signal,
    input  logic       mid_signal,
    input  logic       right_signal,
    output logic [2:0] state,
    output logic       lost,
    output logic       state_chg
);

    localparam int          TW           = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOST_TIMEOUT - 1);

    logic [TW-1:0] tick_cnt_reg;
    logic          tick;
    logic [2:0]    raw;
    logic [2:0]    pattern;

    fsm_t          fsm_reg, fsm_next;
    side_t         side_reg, side_next;
    logic [15:0]   timer_reg, timer_next;
    logic [2:0]    state_reg, state_next;
    logic          lost_reg, lost_next;
    logic          chg_reg;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    assign raw = {left_signal, mid_signal, right_signal};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filter
            sensor_filter #(.FILT_LEN(FILT_LEN)) u_filter (
                .clk      (clk),
                .rst      (rst),
                .tick     (tick),
                .raw      (raw[gi]),
                .filtered (pattern[gi])
            );
        end
    endgenerate

    always_comb begin
        fsm_next   = fsm_reg;
        side_next  = side_reg;
        timer_next = timer_reg;
        state_next = state_reg;
        case (fsm_reg)
            FSM_TRACK: begin
                if (pattern == 3'b000) begin
                    fsm_next   = FSM_LOST;
                    timer_next = 16'd0;
                    state_next = recover_cmd(side_reg);
                end else begin
                    state_next = decode_cmd(pattern, state_reg);
                    side_next  = decode_side(pattern, side_reg);
                end
            end
            FSM_LOST: begin
                // Reacquiring the line takes priority over the timeout.
                if (pattern != 3'b000) begin
                    fsm_next   = FSM_TRACK;
                    timer_next = 16'd0;
                    state_next = decode_cmd(pattern, state_reg);
                    side_next  = decode_side(pattern, side_reg);
                end else begin
                    state_next = recover_cmd(side_reg);
                    if (tick) begin
                        timer_next = timer_reg + 16'd1;
                        if (timer_reg == TIMEOUT_LAST) begin
                            fsm_next   = FSM_HALT;
                            state_next = CMD_STOP;
                        end
                    end
                end
            end
            default: begin  // IDLE and HALT both wait for any line
                state_next = CMD_STOP;
                if (pattern != 3'b000) begin
                    fsm_next   = FSM_TRACK;
                    timer_next = 16'd0;
                    state_next = decode_cmd(pattern, CMD_STOP);
                    side_next  = decode_side(pattern, side_reg);
                end
            end
        endcase
        lost_next = (fsm_next == FSM_LOST) || (fsm_next == FSM_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg   <= FSM_IDLE;
            side_reg  <= SIDE_CENTER;
            timer_reg <= 16'd0;
            state_reg <= CMD_STOP;
            lost_reg  <= 1'b0;
            chg_reg   <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            side_reg  <= side_next;
            timer_reg <= timer_next;
            state_reg <= state_next;
            lost_reg  <= lost_next;
            chg_reg   <= (state_next != state_reg);
        end
    end

    assign state     = state_reg;
    assign lost      = lost_reg;
    assign state_chg = chg_reg;

endmodule
